ksa_mp_share_ctrl: RTL

- Sequencer and arbiter that shares one 32-bit Kogge-Stone adder (KSA32) between two requesters.
- Each request is a WORDS×32-bit add or subtract. The block accepts a request, latches its operands, and feeds the adder one 32-bit word per cycle, LSW first, with the carry held in a register between words.
- It returns the wide result through a valid/ready response port.
- It sits between client datapaths and the single shared adder instance.

---
 rtl/ksa_ctrl_pkg.sv | 19 +
 rtl/ksa32.sv | 39 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/ksa_mp_share_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ksa_ctrl_pkg.sv
// Shared types and constants for the KSA32 share controller.
//   state_t    : controller FSM states
//   DATA_WIDTH : adder word width (fixed by KSA32)
//   REQ0/REQ1  : requester ids as carried on rsp_id / last_grant
//   add_in_t   : one word step presented to the shared adder
package ksa_ctrl_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  cin;
  } add_in_t;
endpackage

// File: rtl/ksa32.sv
// 32-bit Kogge-Stone adder, purely combinational.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low 32 bits)
//   cout : carry out of bit 31
module ksa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  // gk[l]/pk[l]: group generate/propagate after l prefix levels
  logic [31:0] gk [6];
  logic [31:0] pk [6];
  logic [32:0] c;

  always_comb begin
    gk[0] = a & b;
    pk[0] = a ^ b;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << l)) begin
          gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
          pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
        end else begin
          gk[l+1][i] = gk[l][i];
          pk[l+1][i] = pk[l][i];
        end
      end
    end
    // gk[5][i]/pk[5][i] span bits i..0, so cin folds in at the end
    c[0] = cin;
    for (int i = 0; i < 32; i++) c[i+1] = gk[5][i] | (pk[5][i] & cin);
  end

  assign sum  = pk[0] ^ c[31:0];
  assign cout = c[32];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   req  : request vector {req1, req0}
//   upd  : a grant was taken this cycle; remember the winner
//   gnt  : one-hot grant (zero when nobody requests)
//   win  : id of the granted requester (only meaningful when |req)
// last_grant resets to REQ1 so that requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       win
);
  import ksa_ctrl_pkg::*;

  logic last_grant;

  always_comb begin
    win = (req == 2'b11) ? ~last_grant : (req[1] ? REQ1 : REQ0);
    gnt = (req == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_grant <= REQ1;
    else if (upd) last_grant <= win;
  end
endmodule

// File: rtl/ksa_mp_share_ctrl.sv
// Shares one KSA32 between two requesters doing WORDS x 32-bit add/sub.
// Operands are latched at accept, then the adder is stepped one word per
// cycle (LSW first) with the carry kept in carry_q between words.
//   req0_* / req1_* : valid/ready request ports (A, B, sub)
//   rsp_*           : valid/ready response (id, sum, cout[, ovf])
//   busy            : controller is in RUN or DONE
// Optional: define KSA_MP_OVF_EN to add rsp_ovf, the signed overflow of
// the wide result.
module ksa_mp_share_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [DATA_WIDTH*WORDS-1:0] req0_a,
  input  logic [DATA_WIDTH*WORDS-1:0] req0_b,
  input  logic                        req0_sub,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [DATA_WIDTH*WORDS-1:0] req1_a,
  input  logic [DATA_WIDTH*WORDS-1:0] req1_b,
  input  logic                        req1_sub,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic [DATA_WIDTH*WORDS-1:0] rsp_sum,
  output logic                        rsp_cout,
`ifdef KSA_MP_OVF_EN
  output logic                        rsp_ovf,
`endif
  output logic                        busy
);
  import ksa_ctrl_pkg::*;

  if (DATA_WIDTH != ksa_ctrl_pkg::DATA_WIDTH) begin : g_bad_dw
    $error("ksa_mp_share_ctrl: DATA_WIDTH must be 32 to match KSA32");
  end
  if (WORDS < 1 || WORDS > 16) begin : g_bad_words
    $error("ksa_mp_share_ctrl: WORDS must be in 1..16");
  end

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t                              state;
  logic [CW-1:0]                       cnt;
  logic [WORDS-1:0][DATA_WIDTH-1:0]    a_q, b_q, res_q;
  logic                                sub_q, carry_q, id_q, vld_q, busy_q;
`ifdef KSA_MP_OVF_EN
  logic                                ovf_q;
`endif

  // Arbitration
  logic [1:0] gnt;
  logic       win, idle, accept;

  assign idle   = (state == IDLE);
  assign accept = idle & (|gnt);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .upd   (accept),
    .gnt   (gnt),
    .win   (win)
  );

  // Ready only in IDLE; gated by rst_n so every output is 0 while in reset
  assign req0_ready = gnt[0] & idle & rst_n;
  assign req1_ready = gnt[1] & idle & rst_n;

  logic [DATA_WIDTH*WORDS-1:0] sel_a, sel_b;
  logic                        sel_sub;
  assign sel_a   = win ? req1_a   : req0_a;
  assign sel_b   = win ? req1_b   : req0_b;
  assign sel_sub = win ? req1_sub : req0_sub;

  // Shared adder, one word per RUN cycle
  add_in_t         add_in;
  logic [DATA_WIDTH-1:0] add_sum;
  logic            add_cout;

  always_comb begin
    add_in.a   = a_q[cnt];
    add_in.b   = b_q[cnt];
    // Subtraction's +1 enters only on word 0; later words chain the carry
    add_in.cin = (cnt == '0) ? sub_q : carry_q;
  end

  ksa32 u_ksa32 (
    .a    (add_in.a),
    .b    (add_in.b),
    .cin  (add_in.cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      id_q    <= REQ0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef KSA_MP_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q    <= sel_a;
          b_q    <= sel_sub ? ~sel_b : sel_b;
          sub_q  <= sel_sub;
          id_q   <= win;
          cnt    <= '0;
          busy_q <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          res_q[cnt] <= add_sum;
          carry_q    <= add_cout;
          if (cnt == LAST) begin
            vld_q <= 1'b1;
            state <= DONE;
`ifdef KSA_MP_OVF_EN
            ovf_q <= (a_q[cnt][DATA_WIDTH-1] ~^ b_q[cnt][DATA_WIDTH-1]) &
                     (add_sum[DATA_WIDTH-1] ^ a_q[cnt][DATA_WIDTH-1]);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (rsp_ready) begin
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = res_q;
  assign rsp_cout  = carry_q;
  assign busy      = busy_q;
`ifdef KSA_MP_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif
endmodule
